// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between requester blocks and the round-robin hold arbiter.
// master = requester side, slave = arbiter side.
interface rr_hold_arbiter_if #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned CODE_W  = $clog2(NUM_REQ + 1)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [CODE_W-1:0]  gnt_code;
    logic               busy;
    logic               expire;

    modport master (output req, input gnt, input gnt_code, input busy, input expire);
    modport slave  (input req, output gnt, output gnt_code, output busy, output expire);
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered one-hot grants held while requested, capped at MAX_HOLD
// cycles per tenure; the rotation pointer always sits one past the current/last owner.
module rr_hold_arbiter #(
    parameter  int unsigned NUM_REQ  = 3,
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned CODE_W   = $clog2(NUM_REQ + 1),
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1),
    localparam int unsigned PTR_W    = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst,
    rr_hold_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             r_state;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_expire;

    state_e             w_state_d;
    logic [PTR_W-1:0]   w_owner_d;
    logic [PTR_W-1:0]   w_ptr_d;
    logic [CNT_W-1:0]   w_cnt_d;
    logic               w_expire_d;
    logic               w_take;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_win_next;
    int                 w_idx;
    logic [NUM_REQ-1:0] w_gnt;

    // Scan req from r_ptr upward, wrapping; first set bit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_idx = (int'(r_ptr) + k) % int'(NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    assign w_win_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_d  = r_state;
        w_owner_d  = r_owner;
        w_ptr_d    = r_ptr;
        w_cnt_d    = r_cnt;
        w_expire_d = 1'b0;
        w_take     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_take = w_found;
            end
            StBusy: begin
                if (bus.req[r_owner] && (r_cnt < CNT_W'(MAX_HOLD))) begin
                    w_cnt_d = r_cnt + 1'b1;
                end else begin
                    // Owner still requesting here means the tenure hit the hold limit.
                    w_expire_d = bus.req[r_owner];
                    w_take     = w_found;
                    if (!w_found) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_take) begin
            w_state_d = StBusy;
            w_owner_d = w_win;
            w_ptr_d   = w_win_next;
            w_cnt_d   = CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_owner  <= w_owner_d;
            r_ptr    <= w_ptr_d;
            r_cnt    <= w_cnt_d;
            r_expire <= w_expire_d;
        end
    end

    always_comb begin
        w_gnt = '0;
        if (r_state == StBusy) begin
            w_gnt[r_owner] = 1'b1;
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.busy     = (r_state == StBusy);
    assign bus.gnt_code = (r_state == StBusy) ? (CODE_W'(r_owner) + CODE_W'(1)) : '0;
    assign bus.expire   = r_expire;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: directed scenarios plus random traffic,
// checked against a cycle-level round-robin reference model.
module tb_rr_hold_arbiter;

    localparam int N = 3;
    localparam int H = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic [1:0]   code;
        logic         busy;
        logic         expire;
    } exp_t;

    logic clk = 1'b1;
    logic rst = 1'b1;

    rr_hold_arbiter_if #(.NUM_REQ(N)) arb_if ();

    rr_hold_arbiter #(
        .NUM_REQ (N),
        .MAX_HOLD(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(arb_if)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: owner index (-1 when idle), cycles held, next scan start.
    int m_owner  = -1;
    int m_tenure = 0;
    int m_ptr    = 0;

    task automatic model_step(input logic r, input logic [N-1:0] rq);
        exp_t e;
        bit   handoff;
        bit   ex;
        int   w;
        handoff = 0;
        ex      = 0;
        if (r) begin
            m_owner  = -1;
            m_tenure = 0;
            m_ptr    = 0;
        end else begin
            if (m_owner < 0) handoff = 1;
            else if (!rq[m_owner]) handoff = 1;
            else if (m_tenure == H) begin
                handoff = 1;
                ex      = 1;
            end else m_tenure++;
            if (handoff) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                end
                if (w >= 0) begin
                    m_owner  = w;
                    m_tenure = 1;
                    m_ptr    = (w + 1) % N;
                end else begin
                    m_owner  = -1;
                    m_tenure = 0;
                end
            end
        end
        e.gnt    = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.code   = (m_owner >= 0) ? 2'(m_owner + 1) : 2'd0;
        e.busy   = (m_owner >= 0);
        e.expire = ex;
        q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] rq);
        @(negedge clk);
        rst        = r;
        arb_if.req = rq;
        model_step(r, rq);
    endtask

    task automatic hold(input logic [N-1:0] rq, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, rq);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req_v);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        logic prev_exp;
        prev_exp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt",      8'(arb_if.gnt),      8'(e.gnt));
                chk("gnt_code", 8'(arb_if.gnt_code), 8'(e.code));
                chk("busy",     8'(arb_if.busy),     8'(e.busy));
                chk("expire",   8'(arb_if.expire),   8'(e.expire));
                chk("onehot0",  8'($onehot0(arb_if.gnt)), 8'd1);
                chk("busy_or",  8'(arb_if.busy),     8'(|arb_if.gnt));
                chk("expire_2x", 8'(prev_exp && arb_if.expire), 8'd0);
                prev_exp = arb_if.expire;
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        arb_if.req = '0;
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        // Full contention: 4-cycle tenures rotating 0,1,2,0 with expire at hand-offs.
        hold(3'b111, 14);
        // Sole requester re-granted on timeout with no gap.
        hold(3'b010, 10);
        // Release hand-off: owner 0 drops after 2 grant cycles, 2 takes over immediately.
        cycle(1'b1, 3'b000);
        hold(3'b101, 2);
        hold(3'b100, 3);
        // Idle, then single late request.
        hold(3'b000, 5);
        hold(3'b100, 3);
        // Reset mid-tenure of requester 2, then 1 beats 2 from ptr=0.
        cycle(1'b1, 3'b100);
        hold(3'b110, 3);
        // Random traffic with sticky requests and occasional reset.
        rq = '0;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            cycle(($urandom_range(0, 79) == 0), rq);
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Sequential round-robin arbiter that shares one resource among NUM_REQ requesters.
- Grants are registered and one-hot. Each grant is held while the owner keeps its request high, up to MAX_HOLD cycles.
- After reset the priority order is 0,1,2,…, giving the fixed low-index-first order of the existing combinational grant encoder; it then rotates to prevent starvation.
- Sits between requester blocks and the shared resource; gnt_code uses the same encoding as the existing 2-bit grant code (0 = none, i+1 = requester i).

Parameters:
- NUM_REQ, 3, number of requesters; legal range >= 2.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure; legal range >= 1.
- CODE_W, $clog2(NUM_REQ+1), width of gnt_code. Derived; not overridden.
- CNT_W, $clog2(MAX_HOLD+1), width of the internal hold counter. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector; bit i is held high while requester i needs the resource.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_code  output  CODE_W  0 = no grant, i+1 = requester i granted.
- busy  output  1  high whenever any grant is active.
- expire  output  1  one-cycle pulse: the previous tenure was ended by MAX_HOLD timeout.

Behaviour:
- Reset (rst=1 at an edge):
  - gnt=0, gnt_code=0, busy=0, expire=0.
  - State=IDLE, rotation pointer ptr=0, hold_cnt=0.
  - rst overrides everything, including mid-tenure: the grant drops at that edge with no expire pulse.
- States:
  - IDLE: gnt=0.
  - BUSY: exactly one gnt bit set (owner).
- Arbitration function, used on entry from IDLE and on every hand-off:
  - Scan req starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins.
- IDLE -> BUSY:
  - If any req bit is 1 at an edge, the winner's gnt bit rises at that edge (1-cycle registered latency).
  - hold_cnt=1; ptr=(winner+1) mod NUM_REQ.
  - If req==0, stay IDLE.
- BUSY, owner req=1 and hold_cnt<MAX_HOLD: keep grant; hold_cnt+=1; other requests are ignored.
- BUSY, owner req=0 (release):
  - At that edge, arbitrate among current req bits. The owner's bit is 0, so the owner is not eligible.
  - Winner found: grant it at the same edge (no idle gap); hold_cnt=1; update ptr.
  - No winner: go to IDLE, gnt=0.
- BUSY, owner req=1 and hold_cnt==MAX_HOLD (timeout):
  - At that edge, arbitrate with ptr already at owner+1, so the owner is last in order.
  - Another requester wins if present. If the owner is the sole requester, it is re-granted with hold_cnt=1.
  - expire=1 for the one cycle following that edge, in both cases.
- The owner therefore holds for at most MAX_HOLD consecutive cycles per tenure. With MAX_HOLD=1, every tenure lasts one cycle.
- The owner still sees gnt for the one cycle in which it drops req. Requesters must tolerate this.
- A requester raising and dropping req while not the owner has no effect; nothing is queued.
- gnt_code and busy are derived from the same registered state as gnt and are never inconsistent with it.
- Width/wrap rules:
  - ptr wraps from NUM_REQ-1 to 0.
  - hold_cnt never exceeds MAX_HOLD.
  - gnt_code = owner index + 1 in CODE_W bits.
- Assertions in the bench:
  - gnt is onehot0.
  - busy == |gnt.
  - expire is never high in two consecutive cycles unless MAX_HOLD==1.

Test Plan (NUM_REQ=3, MAX_HOLD=4):
1. Release rst, then req=3'b111 held → at the next edge gnt=001, gnt_code=01, busy=1; held 4 cycles, then gnt=010 with expire=1 for 1 cycle.
2. req=3'b111 held 14 cycles → gnt sequence 001×4, 010×4, 100×4, 001…; expire pulses at each hand-off; gnt_code 01, 10, 11, 01.
3. req=3'b010 alone held 10 cycles → gnt=010 continuously, gnt_code=10; expire pulses after cycles 4 and 8 (sole-requester re-grant, no gap).
4. req=3'b101 with owner 0 dropping req[0] after 2 grant cycles → at the next edge gnt=100, gnt_code=11, no idle cycle, expire=0.
5. req=3'b000 from IDLE → gnt=000, gnt_code=00, busy=0 indefinitely. Then req=3'b100 → gnt=100 one edge later.
6. rst pulsed during the tenure of requester 2, then req=3'b110 → gnt=000 at the rst edge with no expire pulse; then gnt=010 (ptr restored to 0, requester 1 wins over 2).
